// File: rtl/card_select_ctrl.sv
// rtl/card_select_ctrl.sv - player cursor and card-pair selection sequencer
//
// Purpose: turns button presses into cursor moves on the card grid and
// captures two selections. It issues a one-cycle compare request, then
// either locks the pair as matched or shows the pair for SHOW_CYCLES
// cycles before hiding it again.
//
// Ports:
//   clock, resetN         rising-edge clock, synchronous active-low reset
//   btnUp/Down/Left/Right synchronized direction button levels
//   btnA                  synchronized select button level
//   cmpDone, cmpMatch     comparator result pulse and match flag
//   cursor                linear cursor index, row*GRID_W+col
//   firstSel, secondSel   indices of the two selected cards
//   cmpReq                one-cycle compare request
//   faceUp, matched       per-card draw masks
//   busy                  high while a pair is being compared or shown
//   allMatched            high once the whole grid is matched
module card_select_ctrl #(
  parameter int GRID_W      = 6,
  parameter int GRID_H      = 6,
  parameter int SHOW_CYCLES = 25000000
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        btnLeft,
  input  logic        btnRight,
  input  logic        btnA,
  input  logic        cmpDone,
  input  logic        cmpMatch,
  output logic [5:0]  cursor,
  output logic [5:0]  firstSel,
  output logic [5:0]  secondSel,
  output logic        cmpReq,
  output logic [35:0] faceUp,
  output logic [35:0] matched,
  output logic        busy,
  output logic        allMatched
);

  localparam int NCARDS = GRID_W * GRID_H;
  localparam int CNT_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  // Bits beyond the populated grid count as already matched.
  localparam logic [35:0] VALID_MASK =
    (NCARDS >= 36) ? {36{1'b1}} : 36'((64'd1 << NCARDS) - 64'd1);

  localparam logic [5:0]       LAST_COL   = 6'(GRID_W - 1);
  localparam logic [5:0]       LAST_ROW   = 6'(GRID_H - 1);
  localparam logic [5:0]       ROW_STRIDE = 6'(GRID_W);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    REQ,
    WAIT_RESULT,
    SHOW,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       row_q, row_d;
  logic [5:0]       col_q, col_d;
  logic [5:0]       cursor_q, cursor_d;
  logic [5:0]       first_sel_q, first_sel_d;
  logic [5:0]       second_sel_q, second_sel_d;
  logic             cmp_req_q, cmp_req_d;
  logic [35:0]      face_up_q, face_up_d;
  logic [35:0]      matched_q, matched_d;
  logic             busy_q, busy_d;
  logic             all_matched_q, all_matched_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Order: up, down, left, right, A.
  logic [4:0]       btn_hist_q, btn_hist_d;
  logic [4:0]       btn_now;
  logic [4:0]       press;

  always_comb begin
    btn_now    = {btnUp, btnDown, btnLeft, btnRight, btnA};
    press      = btn_now & ~btn_hist_q;
    btn_hist_d = btn_now;

    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    first_sel_d   = first_sel_q;
    second_sel_d  = second_sel_q;
    face_up_d     = face_up_q;
    matched_d     = matched_q;
    cnt_d         = cnt_q;

    // One move per cycle; vertical presses take priority over horizontal ones.
    if (state_q != DONE) begin
      if (press[4]) begin
        row_d = (row_q == 6'd0) ? LAST_ROW : row_q - 6'd1;
      end else if (press[3]) begin
        row_d = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
      end else if (press[2]) begin
        col_d = (col_q == 6'd0) ? LAST_COL : col_q - 6'd1;
      end else if (press[1]) begin
        col_d = (col_q == LAST_COL) ? 6'd0 : col_q + 6'd1;
      end
    end

    // Selections use cursor_q, i.e. the position before any same-cycle move.
    case (state_q)
      PICK1: begin
        if (press[0] && !matched_q[cursor_q]) begin
          first_sel_d         = cursor_q;
          face_up_d[cursor_q] = 1'b1;
          state_d             = PICK2;
        end
      end
      PICK2: begin
        if (press[0] && (cursor_q != first_sel_q) && !matched_q[cursor_q]) begin
          second_sel_d        = cursor_q;
          face_up_d[cursor_q] = 1'b1;
          state_d             = REQ;
        end
      end
      REQ: begin
        state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (cmpDone) begin
          if (cmpMatch) begin
            matched_d[first_sel_q]  = 1'b1;
            matched_d[second_sel_q] = 1'b1;
            face_up_d[first_sel_q]  = 1'b1;
            face_up_d[second_sel_q] = 1'b1;
            state_d = (&(matched_d | ~VALID_MASK)) ? DONE : PICK1;
          end else begin
            cnt_d   = SHOW_LOAD;
            state_d = SHOW;
          end
        end
      end
      SHOW: begin
        if (cnt_q == '0) begin
          face_up_d[first_sel_q]  = 1'b0;
          face_up_d[second_sel_q] = 1'b0;
          state_d                 = PICK1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
      end
      default: begin
        state_d = PICK1;
      end
    endcase

    cursor_d      = 6'(row_d * ROW_STRIDE + col_d);
    cmp_req_d     = (state_d == REQ);
    busy_d        = (state_d == REQ) || (state_d == WAIT_RESULT) || (state_d == SHOW);
    all_matched_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q       <= PICK1;
      row_q         <= 6'd0;
      col_q         <= 6'd0;
      cursor_q      <= 6'd0;
      first_sel_q   <= 6'd0;
      second_sel_q  <= 6'd0;
      cmp_req_q     <= 1'b0;
      face_up_q     <= 36'd0;
      matched_q     <= 36'd0;
      busy_q        <= 1'b0;
      all_matched_q <= 1'b0;
      cnt_q         <= '0;
      // Buttons held through reset must not register as presses.
      btn_hist_q    <= 5'b11111;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      cursor_q      <= cursor_d;
      first_sel_q   <= first_sel_d;
      second_sel_q  <= second_sel_d;
      cmp_req_q     <= cmp_req_d;
      face_up_q     <= face_up_d;
      matched_q     <= matched_d;
      busy_q        <= busy_d;
      all_matched_q <= all_matched_d;
      cnt_q         <= cnt_d;
      btn_hist_q    <= btn_hist_d;
    end
  end

  assign cursor     = cursor_q;
  assign firstSel   = first_sel_q;
  assign secondSel  = second_sel_q;
  assign cmpReq     = cmp_req_q;
  assign faceUp     = face_up_q;
  assign matched    = matched_q;
  assign busy       = busy_q;
  assign allMatched = all_matched_q;

endmodule

// File: tb/tb_card_select_ctrl.sv
// tb/tb_card_select_ctrl.sv - directed self-checking bench for card_select_ctrl
module tb_card_select_ctrl;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0, btnA = 1'b0;
  logic        cmpDone = 1'b0, cmpMatch = 1'b0;
  logic [5:0]  cursor, firstSel, secondSel;
  logic        cmpReq, busy, allMatched;
  logic [35:0] faceUp, matched;

  localparam logic [4:0] UP = 5'b10000;
  localparam logic [4:0] DN = 5'b01000;
  localparam logic [4:0] LF = 5'b00100;
  localparam logic [4:0] RT = 5'b00010;
  localparam logic [4:0] BA = 5'b00001;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_row = 0;
  int cur_col = 0;

  card_select_ctrl #(.GRID_W(6), .GRID_H(6), .SHOW_CYCLES(8)) dut (
    .clock(clock), .resetN(resetN),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .btnA(btnA), .cmpDone(cmpDone), .cmpMatch(cmpMatch),
    .cursor(cursor), .firstSel(firstSel), .secondSel(secondSel),
    .cmpReq(cmpReq), .faceUp(faceUp), .matched(matched),
    .busy(busy), .allMatched(allMatched)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btnUp, btnDown, btnLeft, btnRight, btnA} = b;
  endtask

  task automatic press(input logic [4:0] b);
    set_btns(b);
    tick();
    set_btns(5'b0);
    tick();
  endtask

  task automatic do_reset();
    set_btns(5'b0);
    cmpDone = 1'b0;
    cmpMatch = 1'b0;
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    tick();
    cur_row = 0;
    cur_col = 0;
  endtask

  task automatic goto_card(input int idx);
    for (int k = 0; k < 6 && cur_col != idx % 6; k++) begin
      press(RT);
      cur_col = (cur_col + 1) % 6;
    end
    for (int k = 0; k < 6 && cur_row != idx / 6; k++) begin
      press(DN);
      cur_row = (cur_row + 1) % 6;
    end
    check_val("goto_cursor", 64'(cursor), 64'(idx));
  endtask

  task automatic result(input logic m);
    cmpDone = 1'b1;
    cmpMatch = m;
    tick();
    cmpDone = 1'b0;
    cmpMatch = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_val("rst_cursor", 64'(cursor), 64'd0);
    check_val("rst_first", 64'(firstSel), 64'd0);
    check_val("rst_second", 64'(secondSel), 64'd0);
    check_val("rst_cmpreq", 64'(cmpReq), 64'd0);
    check_val("rst_faceup", 64'(faceUp), 64'd0);
    check_val("rst_matched", 64'(matched), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_allmatched", 64'(allMatched), 64'd0);

    // Cursor moves and wrapping
    do_reset();
    press(RT);
    press(RT);
    press(DN);
    check_val("move_r2d1", 64'(cursor), 64'd8);
    do_reset();
    press(LF);
    check_val("wrap_left", 64'(cursor), 64'd5);
    do_reset();
    press(UP);
    check_val("wrap_up", 64'(cursor), 64'd30);

    // Select 3, duplicate select ignored, select 4
    do_reset();
    goto_card(3);
    press(BA);
    check_val("sel1_first", 64'(firstSel), 64'd3);
    check_val("sel1_faceup", 64'(faceUp), 64'h8);
    press(BA);
    check_val("dup_ignored_req", 64'(cmpReq), 64'd0);
    check_val("dup_ignored_busy", 64'(busy), 64'd0);
    goto_card(4);
    set_btns(BA);
    tick();
    check_val("req_high", 64'(cmpReq), 64'd1);
    check_val("req_second", 64'(secondSel), 64'd4);
    check_val("req_faceup", 64'(faceUp), 64'h18);
    set_btns(5'b0);
    tick();
    check_val("req_one_cycle", 64'(cmpReq), 64'd0);
    check_val("wait_busy", 64'(busy), 64'd1);
    tick();
    tick();
    tick();
    result(1'b1);
    check_val("match_mask", 64'(matched), 64'h18);
    check_val("match_faceup", 64'(faceUp), 64'h18);
    check_val("match_busy", 64'(busy), 64'd0);

    // A on matched card 3 is ignored; then pair (0,7) mismatches
    goto_card(3);
    press(BA);
    check_val("matched_sel_ignored", 64'(faceUp), 64'h18);
    goto_card(0);
    press(BA);
    check_val("pick1_after_ignore", 64'(firstSel), 64'd0);
    check_val("pick1_busy", 64'(busy), 64'd0);
    goto_card(7);
    press(BA);
    check_val("pair07_second", 64'(secondSel), 64'd7);
    result(1'b0);
    check_val("show_start_faceup", 64'(faceUp), 64'h99);
    check_val("show_start_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      btnA = (i == 3);
      tick();
      if (i < 8) begin
        check_val("show_faceup", 64'(faceUp), 64'h99);
        check_val("show_busy", 64'(busy), 64'd1);
      end else begin
        check_val("show_end_faceup", 64'(faceUp), 64'h18);
        check_val("show_end_busy", 64'(busy), 64'd0);
      end
    end
    btnA = 1'b0;
    check_val("show_sel_ignored", 64'(secondSel), 64'd7);

    // A held through reset release; Up+Right together; move with A
    btnA = 1'b1;
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
    tick();
    check_val("held_a_faceup", 64'(faceUp), 64'd0);
    check_val("held_a_busy", 64'(busy), 64'd0);
    btnA = 1'b0;
    tick();
    press(UP | RT);
    check_val("up_right_prio", 64'(cursor), 64'd30);
    press(RT | BA);
    check_val("move_sel_first", 64'(firstSel), 64'd30);
    check_val("move_sel_cursor", 64'(cursor), 64'd31);
    check_val("move_sel_faceup", 64'(faceUp), 64'h4000_0000);

    // Match all 18 pairs
    do_reset();
    for (int p = 0; p < 18; p++) begin
      goto_card(2 * p);
      press(BA);
      goto_card(2 * p + 1);
      press(BA);
      result(1'b1);
      if (p == 16) check_val("all_before_last", 64'(allMatched), 64'd0);
    end
    check_val("all_matched", 64'(allMatched), 64'd1);
    check_val("all_mask", 64'(matched), 64'hF_FFFF_FFFF);
    tick();
    tick();
    press(LF);
    check_val("all_stays", 64'(allMatched), 64'd1);
    check_val("done_no_move", 64'(cursor), 64'd35);

    // Reset during WAIT_RESULT
    do_reset();
    press(BA);
    goto_card(1);
    press(BA);
    check_val("wait_before_rst", 64'(busy), 64'd1);
    resetN = 1'b0;
    tick();
    check_val("midrst_faceup", 64'(faceUp), 64'd0);
    check_val("midrst_matched", 64'(matched), 64'd0);
    check_val("midrst_cmpreq", 64'(cmpReq), 64'd0);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("postrst_cmpreq", 64'(cmpReq), 64'd0);
    end
    result(1'b1);
    check_val("stray_done_ignored", 64'(matched), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
